// File: rtl/io_pattern_engine.sv
// Pattern generator (hold / increment / Galois LFSR / walking-one) with a
// programmable step prescaler and a one-cycle-delayed loopback checker.
module io_pattern_engine #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DIV_W     = 8,
  parameter int unsigned      ERR_W     = 8,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 8'hB8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic [WIDTH-1:0] seed,
  input  logic             load,
  input  logic             chk_en,
  input  logic [WIDTH-1:0] chk_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] pat_out,
  output logic             pat_valid,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_flag
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_INC  = 2'b01,
    MODE_LFSR = 2'b10,
    MODE_WALK = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] PAT_ONE = WIDTH'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  logic [WIDTH-1:0] r_pat;
  logic             r_valid;
  logic [DIV_W-1:0] r_presc;
  logic [WIDTH-1:0] r_exp;
  logic [ERR_W-1:0] r_err_cnt;
  logic             r_err_flag;

  mode_e            w_mode;
  logic [WIDTH-1:0] w_next;
  logic             w_step;
  logic             w_mismatch;

  assign w_mode = mode_e'(mode);

  always_comb begin
    w_next = r_pat;
    unique case (w_mode)
      MODE_HOLD: w_next = r_pat;
      MODE_INC:  w_next = r_pat + PAT_ONE;
      MODE_LFSR: begin
        // All-zero is the LFSR lock-up state; escape it to 1.
        if (r_pat == '0)
          w_next = PAT_ONE;
        else if (r_pat[0])
          w_next = (r_pat >> 1) ^ LFSR_TAPS;
        else
          w_next = r_pat >> 1;
      end
      MODE_WALK: begin
        if (r_pat == '0)
          w_next = PAT_ONE;
        else
          w_next = {r_pat[WIDTH-2:0], r_pat[WIDTH-1]};
      end
    endcase
  end

  // Equality compare: a div lowered below the running count wraps via 2^DIV_W.
  assign w_step     = (r_presc == div);
  assign w_mismatch = ena & chk_en & ~load & (chk_in != r_exp);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat   <= '0;
      r_valid <= 1'b0;
      r_presc <= '0;
      r_exp   <= '0;
    end else if (load) begin
      r_pat   <= seed;
      r_valid <= 1'b0;
      r_presc <= '0;
      r_exp   <= seed;
    end else if (ena) begin
      r_exp <= r_pat;
      if (w_step) begin
        r_presc <= '0;
        r_pat   <= w_next;
        r_valid <= 1'b1;
      end else begin
        r_presc <= r_presc + DIV_ONE;
        r_valid <= 1'b0;
      end
    end else begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt  <= '0;
      r_err_flag <= 1'b0;
    end else if (clr_err) begin
      r_err_cnt  <= '0;
      r_err_flag <= 1'b0;
    end else if (w_mismatch) begin
      r_err_flag <= 1'b1;
      if (r_err_cnt != '1)
        r_err_cnt <= r_err_cnt + ERR_ONE;
    end
  end

  assign pat_out   = r_pat;
  assign pat_valid = r_valid;
  assign err_cnt   = r_err_cnt;
  assign err_flag  = r_err_flag;

endmodule

// File: tb/tb_io_pattern_engine.sv
// Scoreboard bench for io_pattern_engine: directed scenarios plus random
// traffic, each cycle checked against an arithmetic reference model.
module tb_io_pattern_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] div = 8'd0;
  logic [7:0] seed = 8'd0;
  logic       load = 1'b0;
  logic       chk_en = 1'b0;
  logic [7:0] chk_in = 8'd0;
  logic       clr_err = 1'b0;
  logic [7:0] pat_out;
  logic       pat_valid;
  logic [7:0] err_cnt;
  logic       err_flag;

  io_pattern_engine #(
    .WIDTH    (8),
    .DIV_W    (8),
    .ERR_W    (8),
    .LFSR_TAPS(8'hB8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .mode     (mode),
    .div      (div),
    .seed     (seed),
    .load     (load),
    .chk_en   (chk_en),
    .chk_in   (chk_in),
    .clr_err  (clr_err),
    .pat_out  (pat_out),
    .pat_valid(pat_valid),
    .err_cnt  (err_cnt),
    .err_flag (err_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] pat;
    logic       valid;
    logic [7:0] cnt;
    logic       flag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // staged stimulus, applied on the next tick
  logic       s_rst = 0, s_ena = 0, s_load = 0, s_chk_en = 0, s_clr = 0;
  logic       s_follow = 1;
  logic [1:0] s_mode = 0;
  logic [7:0] s_div = 0, s_seed = 0, s_chk_in = 0, s_flip = 0;

  // reference model state
  int m_pat = 0, m_valid = 0, m_presc = 0, m_exp = 0, m_cnt = 0, m_flag = 0;

  function automatic int next_pat(int p, int md);
    case (md)
      0: return p;
      1: return (p + 1) % 256;
      2: begin
        if (p == 0) return 1;
        if (p % 2 == 1) return (p / 2) ^ 'hB8;
        return p / 2;
      end
      default: begin
        if (p == 0) return 1;
        return ((p * 2) % 256) + (p / 128);
      end
    endcase
  endfunction

  task automatic tick();
    int mism;
    int np, nv, nps, ne, nc, nf;
    @(negedge clk);
    rst = s_rst; ena = s_ena; mode = s_mode; div = s_div; seed = s_seed;
    load = s_load; chk_en = s_chk_en; clr_err = s_clr;
    chk_in = s_follow ? (8'(m_exp) ^ s_flip) : s_chk_in;
    np = m_pat; nv = 0; nps = m_presc; ne = m_exp; nc = m_cnt; nf = m_flag;
    if (s_rst) begin
      np = 0; nps = 0; ne = 0; nc = 0; nf = 0;
    end else begin
      mism = (s_ena && s_chk_en && !s_load && (int'(chk_in) != m_exp)) ? 1 : 0;
      if (s_load) begin
        np = int'(s_seed); nps = 0; ne = int'(s_seed);
      end else if (s_ena) begin
        ne = m_pat;
        if (m_presc == int'(s_div)) begin
          nps = 0; np = next_pat(m_pat, int'(s_mode)); nv = 1;
        end else begin
          nps = (m_presc + 1) % 256;
        end
      end
      if (s_clr) begin
        nc = 0; nf = 0;
      end else if (mism == 1) begin
        nf = 1;
        nc = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
    end
    m_pat = np; m_valid = nv; m_presc = nps; m_exp = ne; m_cnt = nc; m_flag = nf;
    q.push_back('{pat: 8'(np), valid: nv[0], cnt: 8'(nc), flag: nf[0]});
  endtask

  // observe the DUT just after the edge that applied the last tick
  task automatic peek();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(string name, int act, int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (pat_out !== e.pat || pat_valid !== e.valid ||
            err_cnt !== e.cnt || err_flag !== e.flag) begin
          n_bad++;
          $display("FAIL cycle @%0t: got pat=%02h v=%0b cnt=%0d flag=%0b expected pat=%02h v=%0b cnt=%0d flag=%0b",
                   $time, pat_out, pat_valid, err_cnt, err_flag,
                   e.pat, e.valid, e.cnt, e.flag);
        end
      end
    end
  end

  initial begin : stim
    int pulses, period, zero_seen, wait_cyc;
    s_rst = 1;
    tick(); tick();
    peek();
    chk("reset_pat", int'(pat_out), 0);
    chk("reset_valid", int'(pat_valid), 0);
    chk("reset_err", int'(err_cnt) + int'(err_flag), 0);

    // increment, every cycle
    s_rst = 0; s_ena = 1; s_mode = 2'b01; s_div = 0;
    tick(); peek();
    chk("inc_first", int'(pat_out), 1);
    for (int i = 1; i < 256; i++) tick();
    peek();
    chk("inc_wrap", int'(pat_out), 0);
    chk("inc_valid", int'(pat_valid), 1);
    s_ena = 0;
    repeat (5) tick();
    peek();
    chk("ena_off_pat", int'(pat_out), 0);
    chk("ena_off_valid", int'(pat_valid), 0);

    // prescaler div=3, then drop to div=0 mid-period
    s_ena = 1; s_load = 1; s_seed = 8'h10; s_div = 3;
    tick();
    s_load = 0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      tick(); peek();
      pulses += int'(pat_valid);
    end
    chk("div3_pulses", pulses, 4);
    chk("div3_pat", int'(pat_out), 'h14);
    tick(); tick();
    s_div = 0;
    pulses = 0;
    for (int i = 0; i < 260; i++) begin
      tick(); peek();
      pulses += int'(pat_valid);
    end
    chk("div_wrap_pulses", pulses, 6);

    // LFSR
    s_mode = 2'b10; s_load = 1; s_seed = 8'h01;
    tick();
    s_load = 0;
    period = 0; zero_seen = 0;
    for (int i = 1; i <= 300; i++) begin
      tick(); peek();
      if (i == 1) chk("lfsr_1", int'(pat_out), 'hB8);
      if (i == 2) chk("lfsr_2", int'(pat_out), 'h5C);
      if (i == 3) chk("lfsr_3", int'(pat_out), 'h2E);
      if (pat_out == 8'h00) zero_seen = 1;
      if (pat_out == 8'h01) begin
        period = i;
        break;
      end
    end
    chk("lfsr_period", period, 255);
    chk("lfsr_no_zero", zero_seen, 0);
    s_load = 1; s_seed = 8'h00;
    tick();
    s_load = 0;
    tick(); peek();
    chk("lfsr_escape", int'(pat_out), 1);

    // walking one
    s_mode = 2'b11; s_load = 1; s_seed = 8'h80;
    tick();
    s_load = 0;
    for (int i = 0; i < 9; i++) begin
      tick(); peek();
      chk($sformatf("walk_%0d", i), int'(pat_out), 1 << (i % 8));
    end
    s_load = 1; s_seed = 8'h00;
    tick();
    s_load = 0;
    tick(); peek();
    chk("walk_escape", int'(pat_out), 1);

    // checker with clean loopback, then injected errors
    s_mode = 2'b01; s_chk_en = 1; s_follow = 1; s_flip = 0;
    repeat (100) tick();
    peek();
    chk("clean_cnt", int'(err_cnt), 0);
    chk("clean_flag", int'(err_flag), 0);
    for (int i = 0; i < 3; i++) begin
      s_flip = 8'h04; tick();
      s_flip = 0; tick(); tick();
    end
    peek();
    chk("three_cnt", int'(err_cnt), 3);
    chk("three_flag", int'(err_flag), 1);
    s_flip = 8'h81;
    repeat (300) tick();
    peek();
    chk("sat_cnt", int'(err_cnt), 255);
    s_clr = 1;
    tick();
    s_clr = 0; s_flip = 0;
    peek();
    chk("clr_cnt", int'(err_cnt), 0);
    chk("clr_flag", int'(err_flag), 0);

    // reset wins over load and a mismatch
    s_flip = 8'h01; tick();
    s_rst = 1; s_load = 1; s_seed = 8'h5A;
    tick(); peek();
    chk("rst_prio", int'(pat_out) + int'(pat_valid) + int'(err_cnt) + int'(err_flag), 0);
    s_rst = 0; s_load = 0; s_flip = 0;

    // load wins over a step
    s_div = 0; s_load = 1; s_seed = 8'h33;
    tick(); peek();
    chk("load_pat", int'(pat_out), 'h33);
    chk("load_valid", int'(pat_valid), 0);
    s_load = 0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      s_rst    = ($urandom_range(0, 99) == 0);
      s_load   = ($urandom_range(0, 15) == 0);
      s_ena    = ($urandom_range(0, 7) != 0);
      s_mode   = 2'($urandom_range(0, 3));
      s_div    = 8'($urandom_range(0, 3));
      s_seed   = 8'($urandom);
      s_chk_en = ($urandom_range(0, 1) == 1);
      s_clr    = ($urandom_range(0, 40) == 0);
      s_follow = ($urandom_range(0, 3) != 0);
      s_flip   = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      s_chk_in = 8'($urandom);
      tick();
    end

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #3;
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
